// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch and PC sequencer.
// Fetches one 32-bit word from instruction memory, presents it to decode,
// and computes the next PC (sequential, jump or taken branch) when decode
// consumes the instruction.
//
// Optional feature macro: FETCH_CNT_EN
//   defined   -> adds the fetch_count output, a free-running count of
//                consumed instructions (wraps modulo 2^32).
//   undefined -> no fetch_count port and no counter logic.
//
// Handshakes:
//   imem_req/imem_ready : imem_req is high for the whole FETCH state with
//     imem_addr held at pc; the word is taken on the first rising edge where
//     imem_ready=1. imem_ready is ignored outside FETCH.
//   instr_valid/instr_accept : instr_valid is high for the whole ISSUE state
//     with instr/opcode/funct/pc held; the instruction is consumed on the
//     first rising edge where instr_accept=1, and jump/branch/zero are
//     sampled in that same cycle. instr_accept is ignored outside ISSUE.
//   imem_req and instr_valid are decoded from the registered state only.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // Next-PC candidates; all arithmetic wraps modulo 2^32.
  assign pc4           = pc_q + 32'd4;
  assign jump_target   = {pc4[31:28], instr_q[25:0], 2'b00};
  assign branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_target = pc4 + branch_off;

  // Next-PC select: jump beats branch; a branch is taken only when zero=1.
  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

  // State, PC and instruction registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic: IDLE leaves after one cycle, FETCH waits for memory,
  // ISSUE waits for decode to consume the instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_accept) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state and registers only.
  assign imem_req    = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_ISSUE);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];

`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Count every consumed instruction.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (state_q == ST_ISSUE && instr_accept) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
